ct_merge: RTL and testbench
===========================

// Module: ct_merge
// PURPOSE
//  N-to-1 merge node of the cut-through fabric; counterpart of the split node.
//  Arbitrates NI flow-tagged valid/ready input streams onto one output using round-robin.
//  Grant is packet-locked: held from first beat until the EOP beat is transferred.
//  Sits wherever several flows converge on a shared link; OUT_REG optionally cuts timing.
// PARAMETERS
//  NI       2  number of inputs (>=2)
//  WO       8  data width
//  WF       1  flow_id width
//  OUT_REG  0  0: combinational output path; 1: 2-entry skid buffer on output
// PORTS
//  clk      in   1      clock
//  reset    in   1      asynchronous, active-high reset
//  i_data   in   NI*WO  input data, input k at [WO*k +: WO]
//  i_valid  in   NI     per-input valid
//  i_flow   in   NI*WF  per-input flow_id
//  i_eop    in   NI     per-input end-of-packet, qualified by valid
//  o_ready  out  NI     per-input ready
//  o_data   out  WO     merged data
//  o_valid  out  1      merged valid
//  o_flow   out  WF     flow_id of current beat
//  o_eop    out  1      end-of-packet of current beat
//  i_ready  in   1      downstream ready
// BEHAVIOUR
//  Reset: state IDLE, ptr=0, skid buffer empty, o_valid=0, o_ready=0 while reset high.
//  Transfer: an input beat transfers when i_valid[k] & o_ready[k]. The output transfers when o_valid & i_ready.
//  "accept" = downstream accepts the beat: the output transfer if OUT_REG=0, the write into the skid buffer if OUT_REG=1.
//  Arbiter: in IDLE, winner = first k with i_valid[k], scanning ptr, ptr+1 .. mod NI. Combinational, same cycle.
//  FSM IDLE:
//   - no valid input: nothing granted, o_valid=0.
//   - winner accepted with eop=1: stay IDLE, ptr <= (winner+1) mod NI.
//   - otherwise (not accepted, or accepted with eop=0): -> BUSY, cur <= winner.
//   - Therefore a granted beat never loses its grant while stalled.
//  FSM BUSY:
//   - grant fixed to cur; other inputs see o_ready=0.
//   - if i_valid[cur] drops mid-packet: no output beat, stay BUSY.
//   - accepted beat with eop=1: -> IDLE, ptr <= (cur+1) mod NI.
//  Mux: o_data/o_flow/o_eop come from the granted input. The flow_id is passed unchanged.
//  o_ready[k] = grant[k] & downstream_ready; at most one bit set.
//  OUT_REG=0:
//   - zero latency; downstream_ready = i_ready.
//   - o_valid = i_valid[granted] when a grant exists, else 0.
//  OUT_REG=1:
//   - 2-entry skid buffer; downstream_ready = !full (registered).
//   - latency 1 cycle; sustained throughput 1 beat/cycle.
//   - o_* driven from buffer head; FIFO order preserved.
//   - simultaneous push and pop when count=2 is illegal (ready=0 prevents it).
//   - push and pop in the same cycle at count=1 keeps count=1.
//  ptr wrap: NI-1 -> 0. Single-beat packets (eop on first beat) never enter BUSY.
//  Reset mid-packet: packet truncated, buffer flushed, arbitration restarts at input 0.
//  Reset asserted with i_valid high: no beat transfers while reset is high.
// STRUCTURE
//  ct_defs.vh (shared): ct_clog2 function; width of ptr/cur = ct_clog2(NI), min 1.
//  Sub-module ct_rr_arb (NI, req, ptr -> onehot grant, index); reusable by other fabric nodes.
//  Skid buffer inline, generated only when OUT_REG=1.
// TESTING (NI=3, WO=8, WF=2, both OUT_REG values)
//  1 Single-beat packets on all inputs, i_ready=1:
//    grants 0,1,2,0,... one per cycle; o_flow tracks the source input.
//  2 Input 1 sends 4-beat packet (eop on beat 4); input 0 valid throughout:
//    input 0 stalled until input 1 EOP accepted, then granted next.
//  3 i_ready=0 for 5 cycles with input 2 granted:
//    o_data/o_flow stable, no grant change, beat issued exactly once.
//  4 In BUSY on input 0, i_valid[0] drops for 2 cycles mid-packet while input 1 is valid:
//    o_valid=0 for those cycles (plus latency), grant stays 0.
//  5 Reset asserted mid-packet on input 2:
//    o_valid=0 next cycle; after release with all valid, input 0 wins.
//  6 OUT_REG=1, random i_ready at 50%, 1000 packets:
//    scoreboard shows per-input order kept, no beat interleaving within a packet,
//    and 100% throughput when i_ready=1.

Source files
------------

// File: rtl/ct_merge_pkg.sv
// Shared types and helpers for the cut-through merge node and its arbiter.
package ct_merge_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Index width for an NI-way selector, never narrower than one bit.
    function automatic int ct_clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ct_merge_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after i_ptr wins.
module ct_rr_arb
    import ct_merge_pkg::*;
#(
    parameter int NI = 2,
    parameter int PW = ct_clog2(NI)
) (
    input  logic [NI-1:0] i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [NI-1:0] o_grant,
    output logic [PW-1:0] o_index,
    output logic          o_any
);

    logic [PW-1:0] w_idx [NI];

    // w_idx[gi] is the input examined at scan position gi, i.e. (ptr + gi) mod NI.
    for (genvar gi = 0; gi < NI; gi++) begin : g_rot
        logic [PW:0] w_sum;
        assign w_sum      = {1'b0, i_ptr} + (PW+1)'(gi);
        assign w_idx[gi]  = (w_sum >= (PW+1)'(NI)) ? PW'(w_sum - (PW+1)'(NI)) : PW'(w_sum);
    end

    // Scan from the far end so the position closest to ptr overrides the others.
    always_comb begin
        o_index = '0;
        o_any   = 1'b0;
        for (int j = NI - 1; j >= 0; j--) begin
            if (i_req[w_idx[j]]) begin
                o_index = w_idx[j];
                o_any   = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NI; gi++) begin : g_onehot
        assign o_grant[gi] = o_any && (o_index == PW'(gi));
    end

endmodule

// File: rtl/ct_merge.sv
// N-to-1 packet-locked round-robin merge node with optional 2-entry output skid buffer.
module ct_merge
    import ct_merge_pkg::*;
#(
    parameter int NI      = 2,
    parameter int WO      = 8,
    parameter int WF      = 1,
    parameter int OUT_REG = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NI*WO-1:0] i_data,
    input  logic [NI-1:0]    i_valid,
    input  logic [NI*WF-1:0] i_flow,
    input  logic [NI-1:0]    i_eop,
    output logic [NI-1:0]    o_ready,
    output logic [WO-1:0]    o_data,
    output logic             o_valid,
    output logic [WF-1:0]    o_flow,
    output logic             o_eop,
    input  logic             i_ready
);

    localparam int PW = ct_clog2(NI);

    state_t        r_state;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_cur;

    logic [NI-1:0] w_arb_grant;
    logic [PW-1:0] w_arb_idx;
    logic          w_arb_any;

    logic [NI-1:0] w_busy_grant;
    logic [NI-1:0] w_grant;
    logic [PW-1:0] w_sel_idx;
    logic          w_sel_any;
    logic          w_sel_valid;
    logic [WO-1:0] w_sel_data;
    logic [WF-1:0] w_sel_flow;
    logic          w_sel_eop;
    logic          w_dn_ready;
    logic          w_accept;

    logic [WO-1:0] w_in_data [NI];
    logic [WF-1:0] w_in_flow [NI];

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
        return (idx == PW'(NI - 1)) ? '0 : idx + 1'b1;
    endfunction

    ct_rr_arb #(
        .NI (NI),
        .PW (PW)
    ) u_arb (
        .i_req   (i_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_index (w_arb_idx),
        .o_any   (w_arb_any)
    );

    for (genvar gi = 0; gi < NI; gi++) begin : g_in
        assign w_in_data[gi]    = i_data[WO*gi +: WO];
        assign w_in_flow[gi]    = i_flow[WF*gi +: WF];
        assign w_busy_grant[gi] = (r_cur == PW'(gi));
    end

    // Mid-packet the grant is pinned to r_cur even while its valid is low.
    assign w_grant     = (r_state == ST_BUSY) ? w_busy_grant : w_arb_grant;
    assign w_sel_idx   = (r_state == ST_BUSY) ? r_cur : w_arb_idx;
    assign w_sel_any   = (r_state == ST_BUSY) | w_arb_any;
    assign w_sel_valid = w_sel_any & i_valid[w_sel_idx] & ~reset;
    assign w_sel_data  = w_in_data[w_sel_idx];
    assign w_sel_flow  = w_in_flow[w_sel_idx];
    assign w_sel_eop   = i_eop[w_sel_idx];
    assign w_accept    = w_sel_valid & w_dn_ready;

    assign o_ready = w_grant & {NI{w_dn_ready & ~reset}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_cur   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_any) begin
                        if (w_accept && w_sel_eop) begin
                            r_ptr <= next_idx(w_arb_idx);
                        end else begin
                            r_state <= ST_BUSY;
                            r_cur   <= w_arb_idx;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_accept && w_sel_eop) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= next_idx(r_cur);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    if (OUT_REG == 0) begin : g_direct
        assign w_dn_ready = i_ready;
        assign o_valid    = w_sel_valid;
        assign o_data     = w_sel_data;
        assign o_flow     = w_sel_flow;
        assign o_eop      = w_sel_eop;
    end else begin : g_skid
        logic [WO-1:0] r_buf_data [2];
        logic [WF-1:0] r_buf_flow [2];
        logic [1:0]    r_buf_eop;
        logic          r_wr;
        logic          r_rd;
        logic [1:0]    r_cnt;
        logic          w_push;
        logic          w_pop;

        // Upstream ready depends only on registered occupancy, never on i_ready.
        assign w_dn_ready = (r_cnt != 2'd2);
        assign w_push     = w_accept;
        assign w_pop      = (r_cnt != 2'd0) & i_ready;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_wr  <= 1'b0;
                r_rd  <= 1'b0;
                r_cnt <= 2'd0;
            end else begin
                if (w_push) begin
                    r_wr <= ~r_wr;
                end
                if (w_pop) begin
                    r_rd <= ~r_rd;
                end
                r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
            end
        end

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_buf_data[r_wr] <= w_sel_data;
                r_buf_flow[r_wr] <= w_sel_flow;
                r_buf_eop[r_wr]  <= w_sel_eop;
            end
        end

        assign o_valid = (r_cnt != 2'd0);
        assign o_data  = r_buf_data[r_rd];
        assign o_flow  = r_buf_flow[r_rd];
        assign o_eop   = r_buf_eop[r_rd];
    end

endmodule

// File: tb/tb_ct_merge.sv
// Directed vector tables for both output modes plus a scoreboarded random run on the registered variant.
module tb_ct_merge;

    logic clk;
    logic reset;

    logic [23:0] a_data,  b_data;
    logic [2:0]  a_valid, b_valid;
    logic [5:0]  a_flow,  b_flow;
    logic [2:0]  a_eop,   b_eop;
    logic        a_rdy,   b_rdy;
    logic [2:0]  a_o_ready, b_o_ready;
    logic [7:0]  a_o_data,  b_o_data;
    logic        a_o_valid, b_o_valid;
    logic [1:0]  a_o_flow,  b_o_flow;
    logic        a_o_eop,   b_o_eop;

    int n_vec = 0;
    int n_bad = 0;

    ct_merge #(.NI(3), .WO(8), .WF(2), .OUT_REG(0)) dut_a (
        .clk(clk), .reset(reset),
        .i_data(a_data), .i_valid(a_valid), .i_flow(a_flow), .i_eop(a_eop),
        .o_ready(a_o_ready), .o_data(a_o_data), .o_valid(a_o_valid),
        .o_flow(a_o_flow), .o_eop(a_o_eop), .i_ready(a_rdy)
    );

    ct_merge #(.NI(3), .WO(8), .WF(2), .OUT_REG(1)) dut_b (
        .clk(clk), .reset(reset),
        .i_data(b_data), .i_valid(b_valid), .i_flow(b_flow), .i_eop(b_eop),
        .o_ready(b_o_ready), .o_data(b_o_data), .o_valid(b_o_valid),
        .o_flow(b_o_flow), .o_eop(b_o_eop), .i_ready(b_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    typedef struct packed {
        logic [2:0] valid;
        logic [2:0] eop;
        logic       rdy;
        logic [2:0] x_ready;
        logic       x_valid;
        logic [1:0] x_src;
        logic       x_eop;
    } vec_t;

    vec_t tab_a [23];
    vec_t tab_b [12];

    function automatic vec_t mk(input logic [2:0] v, input logic [2:0] e, input logic r,
                                input logic [2:0] xr, input logic xv, input logic [1:0] xs,
                                input logic xe);
        vec_t t;
        t.valid = v; t.eop = e; t.rdy = r;
        t.x_ready = xr; t.x_valid = xv; t.x_src = xs; t.x_eop = xe;
        return t;
    endfunction

    // Fixed per-input payload used by the directed tables: input k carries 0x11*(k+1), flow 3-k.
    function automatic logic [7:0] src_data(input logic [1:0] s);
        case (s)
            2'd0:    return 8'h11;
            2'd1:    return 8'h22;
            default: return 8'h33;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_vec(input string tag, input vec_t v, input logic [2:0] r_act,
                             input logic val_act, input logic [7:0] d_act,
                             input logic [1:0] f_act, input logic e_act);
        chk({tag, " o_ready"}, 32'(r_act), 32'(v.x_ready));
        chk({tag, " o_valid"}, 32'(val_act), 32'(v.x_valid));
        if (v.x_valid) begin
            chk({tag, " o_data"}, 32'(d_act), 32'(src_data(v.x_src)));
            chk({tag, " o_flow"}, 32'(f_act), 32'(2'd3 - v.x_src));
            chk({tag, " o_eop"},  32'(e_act), 32'(v.x_eop));
        end
        $display("%s valid=%b eop=%b rdy=%b -> o_ready=%b o_valid=%b data=%h flow=%0d eop=%b",
                 tag, v.valid, v.eop, v.rdy, r_act, val_act, d_act, f_act, e_act);
    endtask

    // Scoreboard: per-input queues of {eop, data} in acceptance order.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];

    function automatic void sb_push(input int k, input logic [8:0] v);
        case (k)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic int sb_size(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [8:0] sb_pop(input int k);
        case (k)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    logic [5:0] s_cnt [3];
    int         s_left [3];
    logic [2:0] in_x;

    initial begin
        // Test 1 (single-beat round robin), 2 (packet lock), 3 (stall), 4 (valid gap).
        tab_a[0]  = mk(3'b111, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 1'b1);
        tab_a[1]  = mk(3'b111, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 1'b1);
        tab_a[2]  = mk(3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 1'b1);
        tab_a[3]  = mk(3'b111, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 1'b1);
        tab_a[4]  = mk(3'b011, 3'b001, 1'b1, 3'b010, 1'b1, 2'd1, 1'b0);
        tab_a[5]  = mk(3'b011, 3'b001, 1'b1, 3'b010, 1'b1, 2'd1, 1'b0);
        tab_a[6]  = mk(3'b011, 3'b001, 1'b1, 3'b010, 1'b1, 2'd1, 1'b0);
        tab_a[7]  = mk(3'b011, 3'b011, 1'b1, 3'b010, 1'b1, 2'd1, 1'b1);
        tab_a[8]  = mk(3'b001, 3'b001, 1'b1, 3'b001, 1'b1, 2'd0, 1'b1);
        tab_a[9]  = mk(3'b100, 3'b100, 1'b0, 3'b000, 1'b1, 2'd2, 1'b1);
        tab_a[10] = mk(3'b101, 3'b101, 1'b0, 3'b000, 1'b1, 2'd2, 1'b1);
        tab_a[11] = mk(3'b101, 3'b101, 1'b0, 3'b000, 1'b1, 2'd2, 1'b1);
        tab_a[12] = mk(3'b101, 3'b101, 1'b0, 3'b000, 1'b1, 2'd2, 1'b1);
        tab_a[13] = mk(3'b101, 3'b101, 1'b0, 3'b000, 1'b1, 2'd2, 1'b1);
        tab_a[14] = mk(3'b101, 3'b101, 1'b1, 3'b100, 1'b1, 2'd2, 1'b1);
        tab_a[15] = mk(3'b001, 3'b001, 1'b1, 3'b001, 1'b1, 2'd0, 1'b1);
        tab_a[16] = mk(3'b001, 3'b000, 1'b1, 3'b001, 1'b1, 2'd0, 1'b0);
        tab_a[17] = mk(3'b010, 3'b000, 1'b1, 3'b001, 1'b0, 2'd0, 1'b0);
        tab_a[18] = mk(3'b010, 3'b000, 1'b1, 3'b001, 1'b0, 2'd0, 1'b0);
        tab_a[19] = mk(3'b011, 3'b001, 1'b1, 3'b001, 1'b1, 2'd0, 1'b1);
        tab_a[20] = mk(3'b010, 3'b010, 1'b1, 3'b010, 1'b1, 2'd1, 1'b1);
        tab_a[21] = mk(3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 2'd0, 1'b0);
        tab_a[22] = mk(3'b100, 3'b000, 1'b1, 3'b100, 1'b1, 2'd2, 1'b0);

        // Registered variant: one cycle latency, then a 5-cycle downstream stall.
        tab_b[0]  = mk(3'b111, 3'b111, 1'b1, 3'b001, 1'b0, 2'd0, 1'b1);
        tab_b[1]  = mk(3'b111, 3'b111, 1'b1, 3'b010, 1'b1, 2'd0, 1'b1);
        tab_b[2]  = mk(3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 2'd1, 1'b1);
        tab_b[3]  = mk(3'b111, 3'b111, 1'b1, 3'b001, 1'b1, 2'd2, 1'b1);
        tab_b[4]  = mk(3'b111, 3'b111, 1'b0, 3'b010, 1'b1, 2'd0, 1'b1);
        tab_b[5]  = mk(3'b111, 3'b111, 1'b0, 3'b000, 1'b1, 2'd0, 1'b1);
        tab_b[6]  = mk(3'b111, 3'b111, 1'b0, 3'b000, 1'b1, 2'd0, 1'b1);
        tab_b[7]  = mk(3'b111, 3'b111, 1'b0, 3'b000, 1'b1, 2'd0, 1'b1);
        tab_b[8]  = mk(3'b111, 3'b111, 1'b0, 3'b000, 1'b1, 2'd0, 1'b1);
        tab_b[9]  = mk(3'b111, 3'b111, 1'b1, 3'b000, 1'b1, 2'd0, 1'b1);
        tab_b[10] = mk(3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 2'd1, 1'b1);
        tab_b[11] = mk(3'b111, 3'b111, 1'b1, 3'b001, 1'b1, 2'd2, 1'b1);

        a_data = {8'h33, 8'h22, 8'h11};
        b_data = {8'h33, 8'h22, 8'h11};
        a_flow = {2'd1, 2'd2, 2'd3};
        b_flow = {2'd1, 2'd2, 2'd3};
        a_valid = '0; a_eop = '0; a_rdy = 1'b0;
        b_valid = '0; b_eop = '0; b_rdy = 1'b0;
        reset = 1'b1;

        #2;
        chk("reset a o_valid", 32'(a_o_valid), 32'd0);
        chk("reset a o_ready", 32'(a_o_ready), 32'd0);
        chk("reset b o_valid", 32'(b_o_valid), 32'd0);
        chk("reset b o_ready", 32'(b_o_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 23; i++) begin
            @(posedge clk);
            #1;
            a_valid = tab_a[i].valid;
            a_eop   = tab_a[i].eop;
            a_rdy   = tab_a[i].rdy;
            #3;
            check_vec($sformatf("a[%0d]", i), tab_a[i], a_o_ready, a_o_valid, a_o_data, a_o_flow, a_o_eop);
        end

        // Test 5: reset while input 2 holds a packet open, all inputs valid.
        @(posedge clk);
        #1;
        a_valid = 3'b111;
        a_eop   = 3'b000;
        reset   = 1'b1;
        #1;
        chk("rst-mid a o_valid", 32'(a_o_valid), 32'd0);
        chk("rst-mid a o_ready", 32'(a_o_ready), 32'd0);
        @(posedge clk);
        #4;
        chk("rst-hold a o_valid", 32'(a_o_valid), 32'd0);
        chk("rst-hold a o_ready", 32'(a_o_ready), 32'd0);
        chk("rst-hold b o_valid", 32'(b_o_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        a_eop = 3'b111;
        a_rdy = 1'b1;
        #3;
        chk("rst-after a o_ready", 32'(a_o_ready), 32'b001);
        chk("rst-after a o_valid", 32'(a_o_valid), 32'd1);
        chk("rst-after a o_data",  32'(a_o_data),  32'h11);
        chk("rst-after a o_flow",  32'(a_o_flow),  32'd3);
        $display("reset sequence: o_ready=%b o_data=%h after release", a_o_ready, a_o_data);
        @(posedge clk);
        #1 a_valid = '0;

        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            b_valid = tab_b[i].valid;
            b_eop   = tab_b[i].eop;
            b_rdy   = tab_b[i].rdy;
            #3;
            check_vec($sformatf("b[%0d]", i), tab_b[i], b_o_ready, b_o_valid, b_o_data, b_o_flow, b_o_eop);
        end

        // Test 6: random packets through the registered variant, checked by scoreboard.
        @(posedge clk);
        #1;
        b_valid = '0;
        b_rdy   = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        begin
            int  cyc;
            int  started;
            int  pkts_out;
            int  cur_src;
            bit  in_pkt;
            bit  tput;
            int  src;
            logic [8:0] got;
            logic [8:0] want;

            cyc = 0; started = 0; pkts_out = 0; cur_src = 0; in_pkt = 1'b0;
            in_x = '0;
            for (int k = 0; k < 3; k++) begin
                s_cnt[k] = '0;
                s_left[k] = 0;
            end
            while (cyc < 40000 && pkts_out < 1000) begin
                tput = (cyc < 40);
                for (int k = 0; k < 3; k++) begin
                    if (in_x[k]) begin
                        s_cnt[k]  = s_cnt[k] + 6'd1;
                        s_left[k] = s_left[k] - 1;
                        if (s_left[k] == 0) b_valid[k] = 1'b0;
                    end
                    if (!b_valid[k] && started < 1000 && (tput || $urandom_range(3) != 0)) begin
                        s_left[k]  = int'($urandom_range(4, 1));
                        b_valid[k] = 1'b1;
                        started++;
                    end
                    b_data[8*k +: 8] = {2'(k), s_cnt[k]};
                    b_eop[k]         = (s_left[k] == 1);
                end
                b_rdy = tput ? 1'b1 : 1'($urandom_range(1));
                #3;
                in_x = b_valid & b_o_ready;
                for (int k = 0; k < 3; k++) begin
                    if (in_x[k]) sb_push(k, {b_eop[k], b_data[8*k +: 8]});
                end
                if (tput && cyc >= 2) chk("throughput o_valid", 32'(b_o_valid), 32'd1);
                if (b_o_valid && b_rdy) begin
                    src = 3 - int'(b_o_flow);
                    if (src < 0 || src > 2) begin
                        chk("sb flow range", 32'(b_o_flow), 32'd1);
                    end else begin
                        if (in_pkt) chk("sb interleave src", 32'(src), 32'(cur_src));
                        if (sb_size(src) == 0) begin
                            chk("sb unexpected beat", 32'(sb_size(src)), 32'd1);
                        end else begin
                            want = sb_pop(src);
                            got  = {b_o_eop, b_o_data};
                            chk($sformatf("sb beat src%0d", src), 32'(got), 32'(want));
                        end
                        cur_src = src;
                        in_pkt  = !b_o_eop;
                        if (b_o_eop) begin
                            pkts_out++;
                            $display("pkt %0d out from input %0d at cycle %0d", pkts_out, src, cyc);
                        end
                    end
                end
                cyc++;
                @(posedge clk);
                #1;
            end
            chk("sb packets delivered", 32'(pkts_out), 32'd1000);
            chk("sb queues drained", 32'(sb_size(0) + sb_size(1) + sb_size(2)), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
